booth_seq_ctrl: RTL and testbench
=================================

# booth_seq_ctrl

- Sequencing FSM for the radix-2 Booth signed multiplier.
- Drives the iteration counter register: it issues the load and decrement and reads back the count.
- Drives the A/Q/M datapath registers: it issues load, clear, add, subtract and shift strobes.
- Sits directly upstream of the counter register and consumes its output to decide when the multiply is finished.
- Provides the processor-level start/busy/done handshake.

## Interface

Parameters:
- N, 8: operand width and number of Booth iterations; legal range 1..15 (fits the 4-bit counter).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- Q0  in  1  LSB of multiplier register Q.
- Qm1  in  1  Booth extra bit Q(-1).
- Counter_out  in  4  current iteration count from counter register.
- Counter_in  out  4  load value for counter; constant N.
- Counter_ld  out  1  load counter with Counter_in.
- Counter_dec  out  1  decrement counter.
- M_ld, Q_ld  out  1 each  load multiplicand and multiplier registers.
- A_clr, Qm1_clr  out  1 each  clear accumulator A and Q(-1).
- add, sub  out  1 each  A <= A+M / A <= A-M.
- shift  out  1  arithmetic right shift of {A,Q,Qm1}.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle completion pulse; product valid in {A,Q}.

## Operation

- States: IDLE, LOAD, CHECK, ADD, SUB, SHIFT, DONE.
  - State is held in a register; outputs are a Moore decode of that register.
  - Unused encodings go to IDLE on the next edge.
- IDLE: all strobes 0, busy=0.
  - start=1 -> LOAD.
- LOAD: Counter_ld=M_ld=Q_ld=A_clr=Qm1_clr=1, busy=1.
  - -> CHECK.
- CHECK: busy=1, no strobes.
  - Counter_out==0 -> DONE.
  - Otherwise branch on {Q0,Qm1}: 2'b10 -> SUB; 2'b01 -> ADD; 2'b00 or 2'b11 -> SHIFT.
- ADD / SUB: add=1 (resp. sub=1), busy=1.
  - -> SHIFT.
- SHIFT: shift=1, Counter_dec=1, busy=1.
  - -> CHECK.
- DONE: done=1, busy=0.
  - -> IDLE unconditionally.
  - start is ignored in this state.
- add and sub are never both 1.
- shift never coincides with add or sub.
- Counter_ld and Counter_dec are never both 1.
- Termination is decided only from Counter_out==0 in CHECK. The downstream counter saturates at 0, so no wrap-around is possible.

## Timing

- Reset: state=IDLE.
  - All outputs 0 except Counter_in=N.
  - Visible the cycle after the reset edge.
- Reset asserted in any state aborts the operation.
  - No done pulse is produced.
  - Datapath contents are don't-care.
- start is level-sampled at the edge while in IDLE.
  - LOAD occupies the next cycle.
  - start asserted in LOAD through DONE has no effect.
  - start held high through DONE re-triggers from IDLE one cycle after DONE.
- Per iteration: 2 cycles (CHECK+SHIFT) if no add/sub is needed, 3 cycles (CHECK+ADD/SUB+SHIFT) otherwise.
- Latency, counted in cycles from the start-sampling edge to the DONE cycle: 1 (LOAD) + Σ iterations + 1 (final CHECK) + 1.
  - N=8, no add/sub: done in cycle 19.
  - N=8, add/sub every iteration: done in cycle 27.
- Counter handshake:
  - Counter_out reflects the load in the first CHECK.
  - Each SHIFT's decrement is visible in the following CHECK.
- Q0/Qm1 are sampled in CHECK. They reflect the shift from the previous SHIFT cycle.

## Test plan

The bench models the counter register and the A/Q/M datapath behaviourally.

- Reset: assert reset for 2 cycles, with start=1 from the second cycle.
  - All strobes, busy and done are 0; Counter_in=8.
  - No LOAD occurs until reset is deasserted.
- N=8, Q=0x00, M=0x05:
  - 8 shift pulses, 0 add/sub pulses.
  - done in cycle 19.
  - {A,Q}=16'h0000.
- N=8, Q=0x55 (85), M=0xFD (-3):
  - SUB/ADD alternate every iteration; 8 add/sub pulses.
  - done in cycle 27.
  - {A,Q}=16'hFF01 (-255).
- N=8, Q=0x80 (-128), M=0x80 (-128):
  - exactly one sub (in the final iteration) and no add.
  - {A,Q}=16'h4000 (16384).
- start pulsed again at cycles 5 and 12 of a running multiply:
  - ignored; exactly one done pulse.
  - A start held high through DONE begins a new LOAD in the cycle after IDLE.
- Reset asserted during an ADD state: IDLE next cycle, no done pulse.
  - A following start completes a 3x(-2)=-6 multiply correctly ({A,Q}=16'hFFFA).

Source files
------------

// File: rtl/booth_seq_ctrl_if.sv
// Handshake and strobe bundle between the Booth sequencer and its counter/datapath.
// master = sequencer side, slave = counter register, A/Q/M datapath and requester.
interface booth_seq_ctrl_if;
  logic       start;
  logic       Q0;
  logic       Qm1;
  logic [3:0] Counter_out;
  logic [3:0] Counter_in;
  logic       Counter_ld;
  logic       Counter_dec;
  logic       M_ld;
  logic       Q_ld;
  logic       A_clr;
  logic       Qm1_clr;
  logic       add;
  logic       sub;
  logic       shift;
  logic       busy;
  logic       done;

  modport master (
    input  start, Q0, Qm1, Counter_out,
    output Counter_in, Counter_ld, Counter_dec, M_ld, Q_ld, A_clr, Qm1_clr,
           add, sub, shift, busy, done
  );

  modport slave (
    output start, Q0, Qm1, Counter_out,
    input  Counter_in, Counter_ld, Counter_dec, M_ld, Q_ld, A_clr, Qm1_clr,
           add, sub, shift, busy, done
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiplier sequencer: Moore FSM driving the iteration counter and
// the A/Q/M datapath strobes, plus the start/busy/done handshake.
module booth_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset,
  booth_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic counter_ld;
    logic counter_dec;
    logic m_ld;
    logic q_ld;
    logic a_clr;
    logic qm1_clr;
    logic add;
    logic sub;
    logic shift;
    logic busy;
    logic done;
  } strobe_t;

  state_e  state_q, state_d;
  strobe_t out_q, out_d;

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  function automatic strobe_t decode(input state_e s);
    strobe_t o;
    o = '0;
    case (s)
      S_IDLE: o = '0;
      S_LOAD: begin
        o.counter_ld = 1'b1;
        o.m_ld       = 1'b1;
        o.q_ld       = 1'b1;
        o.a_clr      = 1'b1;
        o.qm1_clr    = 1'b1;
        o.busy       = 1'b1;
      end
      S_CHECK: o.busy = 1'b1;
      S_ADD: begin
        o.add  = 1'b1;
        o.busy = 1'b1;
      end
      S_SUB: begin
        o.sub  = 1'b1;
        o.busy = 1'b1;
      end
      S_SHIFT: begin
        o.shift       = 1'b1;
        o.counter_dec = 1'b1;
        o.busy        = 1'b1;
      end
      S_DONE:  o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next-state logic; termination is decided only in CHECK from the counter value.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: state_d = S_CHECK;
      S_CHECK: begin
        if (bus.Counter_out == 4'd0) begin
          state_d = S_DONE;
        end else begin
          case ({bus.Q0, bus.Qm1})
            2'b10:   state_d = S_SUB;
            2'b01:   state_d = S_ADD;
            default: state_d = S_SHIFT;
          endcase
        end
      end
      S_ADD:   state_d = S_SHIFT;
      S_SUB:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign out_d = decode(state_d);

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.Counter_in  = 4'(N);
  assign bus.Counter_ld  = out_q.counter_ld;
  assign bus.Counter_dec = out_q.counter_dec;
  assign bus.M_ld        = out_q.m_ld;
  assign bus.Q_ld        = out_q.q_ld;
  assign bus.A_clr       = out_q.a_clr;
  assign bus.Qm1_clr     = out_q.qm1_clr;
  assign bus.add         = out_q.add;
  assign bus.sub         = out_q.sub;
  assign bus.shift       = out_q.shift;
  assign bus.busy        = out_q.busy;
  assign bus.done        = out_q.done;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: behavioural counter and A/Q/M datapath around the DUT,
// with a scoreboard of expected products, latencies and strobe counts.
module tb_booth_seq_ctrl;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
    int          nadd;
    int          nsub;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [7:0] op_q, op_m;

  logic [8:0] a_q;
  logic [7:0] q_q, m_q;
  logic       qm1_q;
  logic [3:0] cnt_q;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0, nadd = 0, nsub = 0, nsh = 0;
  exp_t sb[$];

  logic [10:0] outs_s;
  localparam logic [10:0] LOAD_PAT = 11'b1_0_1_1_1_1_0_0_0_1_0;

  booth_seq_ctrl_if bus ();

  booth_seq_ctrl #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.start       = start;
  assign bus.Q0          = q_q[0];
  assign bus.Qm1         = qm1_q;
  assign bus.Counter_out = cnt_q;
  assign outs_s = {bus.Counter_ld, bus.Counter_dec, bus.M_ld, bus.Q_ld, bus.A_clr,
                   bus.Qm1_clr, bus.add, bus.sub, bus.shift, bus.busy, bus.done};

  // Counter register (saturating at zero) and 9-bit-A Booth datapath.
  always @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else if (bus.Counter_ld) cnt_q <= bus.Counter_in;
    else if (bus.Counter_dec && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    if (bus.M_ld) m_q <= op_m;
    if (bus.Q_ld) q_q <= op_q;
    if (bus.A_clr) a_q <= 9'd0;
    if (bus.Qm1_clr) qm1_q <= 1'b0;
    if (bus.add) a_q <= a_q + {m_q[7], m_q};
    if (bus.sub) a_q <= a_q - {m_q[7], m_q};
    if (bus.shift) begin
      a_q   <= {a_q[8], a_q[8:1]};
      q_q   <= {a_q[0], q_q[7:1]};
      qm1_q <= q_q[0];
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t booth_exp(input logic [7:0] q, input logic [7:0] m);
    exp_t e;
    logic signed [15:0] qs, ms, p;
    logic prev;
    qs = {{8{q[7]}}, q};
    ms = {{8{m[7]}}, m};
    p  = qs * ms;
    e.prod = p;
    e.cyc  = 3;
    e.nadd = 0;
    e.nsub = 0;
    prev   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      case ({q[i], prev})
        2'b10: begin e.nsub++; e.cyc += 3; end
        2'b01: begin e.nadd++; e.cyc += 3; end
        default: e.cyc += 2;
      endcase
      prev = q[i];
    end
    return e;
  endfunction

  // Monitor: strobe exclusivity, per-multiply cycle/strobe counts, scoreboard pop on done.
  always @(negedge clk) begin
    chk_val("excl", {29'd0, bus.add & bus.sub, bus.shift & (bus.add | bus.sub),
                     bus.Counter_ld & bus.Counter_dec}, 32'd0);
    if (bus.Counter_ld) begin
      cyc <= 1; nadd <= 0; nsub <= 0; nsh <= 0;
    end else begin
      cyc  <= cyc + 1;
      nadd <= nadd + int'(bus.add);
      nsub <= nsub + int'(bus.sub);
      nsh  <= nsh + int'(bus.shift);
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      chk_val("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        chk_val("product", {16'd0, a_q[7:0], q_q}, {16'd0, sb[0].prod});
        chk_val("latency", cyc + 1, sb[0].cyc);
        chk_val("n_add", nadd, sb[0].nadd);
        chk_val("n_sub", nsub, sb[0].nsub);
        chk_val("n_shift", nsh, 32'd8);
        sb.delete(0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      step();
      n++;
    end
    chk_val("done_seen", {31'd0, done_cnt >= target}, 32'd1);
    step();
  endtask

  task automatic run_mul(input logic [7:0] q, input logic [7:0] m);
    int base;
    op_q = q;
    op_m = m;
    sb.push_back(booth_exp(q, m));
    base  = done_cnt;
    start = 1'b1;
    step();
    chk_val("load_strobes", {21'd0, outs_s}, {21'd0, LOAD_PAT});
    start = 1'b0;
    wait_done(base + 1);
  endtask

  initial begin
    int base, n;
    reset = 1'b1;
    start = 1'b0;
    op_q  = 8'h00;
    op_m  = 8'h00;
    step();
    chk_val("rst_outs_1", {21'd0, outs_s}, 32'd0);
    chk_val("rst_cnt_in", {28'd0, bus.Counter_in}, 32'd8);
    start = 1'b1;
    step();
    chk_val("rst_outs_2", {21'd0, outs_s}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    step();
    chk_val("idle_outs", {21'd0, outs_s}, 32'd0);

    run_mul(8'h00, 8'h05);
    run_mul(8'h55, 8'hFD);
    run_mul(8'h80, 8'h80);

    // Restarts during a running multiply, then start held high through DONE.
    op_q = 8'h55;
    op_m = 8'hFD;
    sb.push_back(booth_exp(8'h55, 8'hFD));
    base  = done_cnt;
    start = 1'b1;
    step();
    chk_val("load_strobes2", {21'd0, outs_s}, {21'd0, LOAD_PAT});
    for (int c = 2; c <= 28; c++) begin
      start = (c == 6) || (c == 13) || (c >= 21);
      if (c == 21) begin
        op_q = 8'h07;
        op_m = 8'h09;
        sb.push_back(booth_exp(8'h07, 8'h09));
      end
      step();
    end
    chk_val("one_done", done_cnt, base + 1);
    chk_val("idle_after_done", {29'd0, bus.busy, bus.Counter_ld, bus.done}, 32'd0);
    step();
    chk_val("retrigger_load", {21'd0, outs_s}, {21'd0, LOAD_PAT});
    start = 1'b0;
    wait_done(base + 2);

    // Abort a multiply with reset while in ADD.
    op_q = 8'h55;
    op_m = 8'hFD;
    sb.push_back(booth_exp(8'h55, 8'hFD));
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!bus.add && n < 20) begin
      step();
      n++;
    end
    chk_val("saw_add", {31'd0, bus.add}, 32'd1);
    base  = done_cnt;
    reset = 1'b1;
    step();
    chk_val("abort_idle", {21'd0, outs_s}, 32'd0);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 40; i++) step();
    chk_val("no_done_after_abort", done_cnt, base);
    run_mul(8'h03, 8'hFE);

    chk_val("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
